// File: rtl/seg_capture.sv
// seg_capture: monitor for a multiplexed 4-digit, active-low seven-segment
// display. Each anode dwell has to stay stable for SETTLE edges. The sampled
// glyph is then decoded back to a hex nibble, and one complete R->RC->LC->L
// scan is assembled into a 16-bit word.
//
// Ports:
//   clk          system clock, rising edge
//   btnC         synchronous active-high reset
//   an[3:0]      anode strobes, active-low; an[0]=R .. an[3]=L
//   seg[6:0]     segment lines, active-low, {G,F,E,D,C,B,A}
//   digits[15:0] last committed frame {L,LC,RC,R}
//   seg_bad[3:0] per digit of the last frame: glyph not in the decode table
//   frame_valid  one-cycle pulse when digits/seg_bad update
//   seq_err      one-cycle pulse on an out-of-order or multi-hot anode
//   frame_count  committed frames, wraps 255->0
module seg_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  seg_bad,
  output logic        frame_valid,
  output logic        seq_err,
  output logic [7:0]  frame_count
);

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic [7:0]       cnt;
  logic [1:0]       ptr;
  logic [2:0][3:0]  sh_nib;   // R, RC, LC of the frame being assembled
  logic [2:0]       sh_bad;

  logic             same;
  logic             strobe;
  logic [3:0]       dec_nib;
  logic             dec_bad;
  logic [3:0]       exp_an;
  logic [2:0]       zeros;

  // Stability tracking compares the live ports against last edge's copy.
  assign same   = ({an, seg} == {an_r, seg_r});
  // Only the SETTLE-1 -> SETTLE step fires. cnt then saturates, so each
  // dwell produces exactly one strobe however long it lasts.
  assign strobe = same && (cnt == SETTLE_M1);
  assign exp_an = ~(4'b0001 << ptr);

  always_comb begin
    zeros = '0;
    for (int i = 0; i < 4; i++) zeros = zeros + {2'b00, ~an_r[i]};
  end

  // Segment pattern back to a nibble. Unknown glyphs, blank included, give 0
  // with the bad flag set.
  always_comb begin
    dec_nib = 4'h0;
    dec_bad = 1'b0;
    case (seg_r)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      default:    dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      an_r        <= 4'b1111;
      seg_r       <= 7'h7F;
      cnt         <= '0;
      ptr         <= '0;
      sh_nib      <= '0;
      sh_bad      <= '0;
      digits      <= '0;
      seg_bad     <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      an_r        <= an;
      seg_r       <= seg;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;

      if (!same)                cnt <= '0;
      else if (cnt != SETTLE_C) cnt <= cnt + 8'd1;

      // A blanked display (all anodes off) is inter-digit dead time, so it
      // is ignored.
      if (strobe && an_r != 4'b1111) begin
        if (zeros > 3'd1) begin
          seq_err <= 1'b1;
          ptr     <= '0;
        end else if (an_r == exp_an) begin
          if (ptr == 2'd3) begin
            // The last digit goes straight to the outputs with the shadow,
            // so the whole frame updates on a single edge.
            digits      <= {dec_nib, sh_nib[2], sh_nib[1], sh_nib[0]};
            seg_bad     <= {dec_bad, sh_bad};
            frame_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
            ptr         <= '0;
          end else begin
            sh_nib[ptr] <= dec_nib;
            sh_bad[ptr] <= dec_bad;
            ptr         <= ptr + 2'd1;
          end
        end else begin
          seq_err <= 1'b1;
          // An unexpected R starts a new scan right away, so it is kept as
          // the first digit instead of being lost.
          if (an_r == 4'b1110) begin
            sh_nib[0] <= dec_nib;
            sh_bad[0] <= dec_bad;
            ptr       <= 2'd1;
          end else begin
            ptr <= '0;
          end
        end
      end
    end
  end

endmodule
